// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - RV32I control encodings, state codes and immediate-format decode
package multicycle_controller_pkg;

  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_LUI = 3'b011;
  localparam logic [2:0] IMM_JAL = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [13:0] {
    S_FETCH     = 14'h0001,
    S_DECODE    = 14'h0002,
    S_MEM_ADR   = 14'h0004,
    S_MEM_READ  = 14'h0008,
    S_MEM_WB    = 14'h0010,
    S_MEM_WRITE = 14'h0020,
    S_EXEC_R    = 14'h0040,
    S_EXEC_I    = 14'h0080,
    S_EXEC_LUI  = 14'h0100,
    S_ALU_WB    = 14'h0200,
    S_BRANCH    = 14'h0400,
    S_EXEC_JALR = 14'h0800,
    S_JAL       = 14'h1000,
    S_TRAP      = 14'h2000
  } state_t;

  function automatic logic [2:0] imm_src_of(input logic [6:0] opc);
    case (opc)
      OPC_SW:  return IMM_S;
      OPC_B:   return IMM_B;
      OPC_LUI: return IMM_LUI;
      OPC_JAL: return IMM_JAL;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// rtl/multicycle_controller_branch_cond.sv - branch-taken decision from funct3 and ALU flags of rs1-rs2
module multicycle_controller_branch_cond
  import multicycle_controller_pkg::*;
(
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       neg,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (f3)
      F3_BEQ:  take = zero;
      F3_BNE:  take = ~zero;
      F3_BLT:  take = neg;
      F3_BGE:  take = ~neg | zero;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory handshake, bus timeout and illegal trap
// Optional perf counters (cycle_cnt, instret_cnt, CNT_W) are built only when PERF_CNT_EN is defined.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
`ifdef PERF_CNT_EN
  , parameter int CNT_W  = 32
`endif
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opc,
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_err
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              take, timeout;
  logic              mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, retire_c;
  logic              set_illegal, set_bus_err;

  multicycle_controller_branch_cond u_branch_cond (
    .f3   (f3),
    .zero (zero),
    .neg  (neg),
    .take (take)
  );

  // A ready arriving on the limit cycle completes the access instead of trapping.
  assign timeout = (WAIT_MAX != 0) && mem_req_c && !mem_ready && (wait_cnt == WAIT_LIM);

  always_comb begin
    next_state  = state;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    retire_c    = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_ADD;
    result_src  = RES_ALUOUT;
    imm_src     = (state == S_FETCH) ? IMM_I : imm_src_of(opc);
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          next_state = S_DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          next_state  = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opc)
          OPC_LW, OPC_SW: next_state = S_MEM_ADR;
          OPC_R:          next_state = S_EXEC_R;
          OPC_I:          next_state = S_EXEC_I;
          OPC_B:          next_state = S_BRANCH;
          OPC_JAL:        next_state = S_JAL;
          OPC_JALR:       next_state = S_EXEC_JALR;
          OPC_LUI:        next_state = S_EXEC_LUI;
          default: begin
            set_illegal = 1'b1;
            next_state  = S_TRAP;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = (opc == OPC_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src   = 1'b1;
        mem_req_c = 1'b1;
        if (mem_ready) begin
          next_state = S_MEM_WB;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          next_state  = S_TRAP;
        end
      end
      S_MEM_WB: begin
        result_src  = RES_MEM;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src     = 1'b1;
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          retire_c   = 1'b1;
          next_state = S_FETCH;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          next_state  = S_TRAP;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_RTYPE;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_ITYPE;
        next_state = S_ALU_WB;
      end
      S_EXEC_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_SUB;
        pc_write_c = take;
        retire_c   = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = S_JAL;
      end
      S_JAL: begin
        // ALUOut holds the jump target; the ALU now forms the link value old_pc+4.
        pc_write_c = 1'b1;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        next_state = S_ALU_WB;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  assign mem_req       = rst & mem_req_c;
  assign mem_write     = rst & mem_write_c;
  assign ir_write      = rst & ir_write_c;
  assign pc_write      = rst & pc_write_c;
  assign reg_write     = rst & reg_write_c;
  assign instr_retired = rst & retire_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (next_state != state &&
          (next_state == S_FETCH || next_state == S_MEM_READ || next_state == S_MEM_WRITE))
        wait_cnt <= '0;
      else if (mem_req_c && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire_c) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench: vector table, random instructions vs. latency model, corner sequences
module tb_multicycle_controller;

  localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011, T_I = 7'b0010011;
  localparam logic [6:0] T_B = 7'b1100011, T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_LUI = 7'b0110111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, zero, neg, mem_ready, rst3, mem_ready3;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_retired, illegal, bus_err;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       mem_req3, mem_write3, adr_src3, ir_write3, pc_write3, reg_write3, instr_retired3, illegal3, bus_err3;
  logic [1:0] alu_src_a3, alu_src_b3, alu_op3, result_src3;
  logic [2:0] imm_src3;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt, cycle_cnt3, instret_cnt3;
`endif

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .f3(f3), .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src), .instr_retired(instr_retired),
    .illegal(illegal), .bus_err(bus_err)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  multicycle_controller #(.WAIT_MAX(3)) dut3 (
    .clk(clk), .rst(rst3), .opc(opc), .f3(f3), .zero(zero), .neg(neg), .mem_ready(mem_ready3),
    .mem_req(mem_req3), .mem_write(mem_write3), .adr_src(adr_src3), .ir_write(ir_write3),
    .pc_write(pc_write3), .reg_write(reg_write3), .alu_src_a(alu_src_a3), .alu_src_b(alu_src_b3),
    .alu_op(alu_op3), .imm_src(imm_src3), .result_src(result_src3), .instr_retired(instr_retired3),
    .illegal(illegal3), .bus_err(bus_err3)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt3), .instret_cnt(instret_cnt3)
`endif
  );

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       zero;
    logic       neg;
    int         cycles;
    int         pcw;
    int         rw;
    int         mw;
    logic [2:0] imm;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int retired_since_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: per-instruction totals derived from instruction class, branch rule and memory waits.
  task automatic ref_model(input logic [6:0] o, input logic [2:0] f, input logic z, input logic n,
                           output int cyc, output int pcw, output int rw, output int mw,
                           output logic [2:0] imm);
    bit take;
    take = (f == 3'd0 && z) || (f == 3'd1 && !z) || (f == 3'd4 && n) || (f == 3'd5 && (!n || z));
    pcw = 1; rw = 1; mw = 0; imm = 3'd0; cyc = 4;
    case (o)
      T_LW:   cyc = 5;
      T_SW:   begin rw = 0; mw = 1; imm = 3'd1; end
      T_B:    begin cyc = 3; rw = 0; imm = 3'd2; pcw = take ? 2 : 1; end
      T_LUI:  imm = 3'd3;
      T_JAL:  begin pcw = 2; imm = 3'd4; end
      T_JALR: begin cyc = 5; pcw = 2; end
      default: ;
    endcase
  endtask

  // Acts as the memory (fixed_lat<0: random 0..3 wait cycles per request) and tallies strobes.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic z, input logic n,
                           input int fixed_lat, output int cyc, output int pcw, output int rw,
                           output int mw, output int waits, output logic [2:0] imm_d, output int proto_bad);
    int  lat, w;
    bit  done, got_imm;
    opc = o; f3 = f; zero = z; neg = n;
    cyc = 0; pcw = 0; rw = 0; mw = 0; waits = 0; proto_bad = 0; imm_d = 3'bx;
    lat = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
    w = 0; done = 0; got_imm = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (mem_req && w == lat) mem_ready = 1'b1;
      else begin
        mem_ready = 1'b0;
        if (mem_req) begin w++; waits++; end
      end
      #1;
      cyc++;
      if (!mem_req && !got_imm) begin imm_d = imm_src; got_imm = 1; end
      if (mem_write && !mem_req) proto_bad++;
      if (mem_req && mem_ready) begin
        if (mem_write) mw++;
        lat = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
        w = 0;
      end
      if (pc_write) pcw++;
      if (reg_write) begin
        rw++;
        if (result_src !== ((o == T_LW) ? 2'b01 : 2'b00)) proto_bad++;
      end
      if (instr_retired) begin done = 1; retired_since_rst++; end
      @(negedge clk);
    end
    if (!done) cyc = -1;
    mem_ready = 1'b0;
    #1;
    check("single_retire", {31'd0, instr_retired}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    retired_since_rst = 0;
  endtask

  vec_t tbl[14];
  int cyc, pcw, rw, mw, waits, pbad, e_cyc, e_pcw, e_rw, e_mw, strobes;
  logic [2:0] imm_d, e_imm;
  logic [6:0] legal[8];

  initial begin
    tbl[0]  = '{T_R,    3'd0, 1'b0, 1'b0, 4, 1, 1, 0, 3'd0};
    tbl[1]  = '{T_I,    3'd0, 1'b0, 1'b0, 4, 1, 1, 0, 3'd0};
    tbl[2]  = '{T_LUI,  3'd0, 1'b0, 1'b0, 4, 1, 1, 0, 3'd3};
    tbl[3]  = '{T_LW,   3'd2, 1'b0, 1'b0, 5, 1, 1, 0, 3'd0};
    tbl[4]  = '{T_SW,   3'd2, 1'b0, 1'b0, 4, 1, 0, 1, 3'd1};
    tbl[5]  = '{T_B,    3'd0, 1'b1, 1'b0, 3, 2, 0, 0, 3'd2};
    tbl[6]  = '{T_B,    3'd0, 1'b0, 1'b0, 3, 1, 0, 0, 3'd2};
    tbl[7]  = '{T_B,    3'd1, 1'b0, 1'b1, 3, 2, 0, 0, 3'd2};
    tbl[8]  = '{T_B,    3'd4, 1'b0, 1'b1, 3, 2, 0, 0, 3'd2};
    tbl[9]  = '{T_B,    3'd5, 1'b0, 1'b1, 3, 1, 0, 0, 3'd2};
    tbl[10] = '{T_B,    3'd5, 1'b1, 1'b1, 3, 2, 0, 0, 3'd2};
    tbl[11] = '{T_B,    3'd2, 1'b1, 1'b1, 3, 1, 0, 0, 3'd2};
    tbl[12] = '{T_JAL,  3'd0, 1'b0, 1'b0, 4, 2, 1, 0, 3'd4};
    tbl[13] = '{T_JALR, 3'd0, 1'b0, 1'b0, 5, 2, 1, 0, 3'd0};
    legal = '{T_LW, T_SW, T_R, T_I, T_B, T_JAL, T_JALR, T_LUI};

    opc = T_I; f3 = 3'd0; zero = 1'b0; neg = 1'b0;
    rst3 = 1'b0; mem_ready3 = 1'b0;
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_strobes", {27'd0, mem_write, ir_write, pc_write, reg_write, instr_retired}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    do_reset();
    #1;
    check("rel_fetch_req", {30'd0, mem_req, adr_src}, 32'd2);
    @(negedge clk);

    foreach (tbl[i]) begin
      run_instr(tbl[i].opc, tbl[i].f3, tbl[i].zero, tbl[i].neg, 0, cyc, pcw, rw, mw, waits, imm_d, pbad);
      check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cycles);
      check($sformatf("tbl%0d_pc_write", i), pcw, tbl[i].pcw);
      check($sformatf("tbl%0d_reg_write", i), rw, tbl[i].rw);
      check($sformatf("tbl%0d_mem_write", i), mw, tbl[i].mw);
      check($sformatf("tbl%0d_imm_src", i), {29'd0, imm_d}, {29'd0, tbl[i].imm});
      check($sformatf("tbl%0d_protocol", i), pbad, 0);
    end

    run_instr(T_I, 3'd0, 1'b0, 1'b0, 1, cyc, pcw, rw, mw, waits, imm_d, pbad);
    check("addi_lat1_cycles", cyc, 5);
    check("addi_lat1_reg_write", rw, 1);
    check("addi_lat1_result_src", pbad, 0);

    // Reset asserted while a load waits in MEM_READ.
    opc = T_LW;
    for (int k = 0; k < 3; k++) begin
      #1 mem_ready = 1'b1; #1;
      @(negedge clk);
    end
    #1 mem_ready = 1'b0; #1;
    check("lw_memread_req", {30'd0, mem_req, adr_src}, 32'd3);
    rst = 1'b0; #1;
    check("rst_drops_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); #1;
    check("rst_hold_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1; retired_since_rst = 0; #1;
    check("after_rst_fetch", {30'd0, mem_req, adr_src}, 32'd2);
    check("after_rst_flags", {30'd0, illegal, bus_err}, 32'd0);
`ifdef PERF_CNT_EN
    check("after_rst_cycle_cnt", cycle_cnt, 32'd0);
    check("after_rst_instret_cnt", instret_cnt, 32'd0);
`endif
    @(negedge clk);

    opc = T_JALR;
    for (int k = 0; k < 5; k++) begin
      #1 mem_ready = 1'b1; #1;
      if (k == 2) check("jalr_exec", {27'd0, pc_write, alu_src_a, alu_src_b}, {27'd0, 1'b0, 2'b10, 2'b01});
      if (k == 3) check("jalr_jal", {29'd0, pc_write, result_src}, {29'd0, 1'b1, 2'b00});
      if (k == 4) check("jalr_wb", {30'd0, reg_write, instr_retired}, 32'd3);
      @(negedge clk);
    end
    retired_since_rst++;
    mem_ready = 1'b0;

    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      logic [2:0] f;
      logic z, n;
      o = legal[$urandom_range(0, 7)];
      f = 3'($urandom_range(0, 7));
      z = 1'($urandom); n = 1'($urandom);
      ref_model(o, f, z, n, e_cyc, e_pcw, e_rw, e_mw, e_imm);
      run_instr(o, f, z, n, -1, cyc, pcw, rw, mw, waits, imm_d, pbad);
      check($sformatf("rnd%0d_cycles opc=%b", i, o), cyc, e_cyc + waits);
      check($sformatf("rnd%0d_pc_write", i), pcw, e_pcw);
      check($sformatf("rnd%0d_reg_write", i), rw, e_rw);
      check($sformatf("rnd%0d_mem_write", i), mw, e_mw);
      check($sformatf("rnd%0d_imm_src", i), {29'd0, imm_d}, {29'd0, e_imm});
      check($sformatf("rnd%0d_protocol", i), pbad, 0);
    end
`ifdef PERF_CNT_EN
    check("instret_cnt", instret_cnt, retired_since_rst);
`endif

    // Illegal opcode: trap is terminal and silent until reset.
    opc = 7'b1111111;
    #1 mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    check("illegal_not_early", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      #1 mem_ready = 1'($urandom); #1;
      if (mem_req | mem_write | ir_write | pc_write | reg_write | instr_retired) strobes++;
      if (!illegal) strobes++;
      @(negedge clk);
    end
    check("trap_silent", strobes, 0);
    check("trap_bus_err", {31'd0, bus_err}, 32'd0);
    do_reset(); #1;
    check("trap_cleared", {30'd0, illegal, mem_req}, 32'd1);

    // WAIT_MAX=3: no ready in FETCH -> bus error after three wait cycles.
    opc = T_I;
    rst3 = 1'b0; mem_ready3 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 3) check("to_not_yet", {30'd0, bus_err3, mem_req3}, 32'd1);
      @(negedge clk);
    end
    #1;
    check("to_bus_err", {30'd0, bus_err3, mem_req3}, 32'd2);
    @(negedge clk); @(negedge clk); #1;
    check("to_sticky", {30'd0, bus_err3, mem_req3}, 32'd2);
    rst3 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst3 = 1'b1; #1;
    check("to_rst_clear", {31'd0, bus_err3}, 32'd0);
    @(negedge clk);
    for (int k = 1; k < 4; k++) begin
      #1 mem_ready3 = (k == 3); #1;
      if (k == 3) check("to_ready_wins", {31'd0, ir_write3}, 32'd1);
      @(negedge clk);
    end
    mem_ready3 = 1'b0; #1;
    check("to_no_err", {30'd0, bus_err3, mem_req3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
